adc_serial_capture_multi: RTL and testbench

Parametrised multi-channel serial ADC capture engine, the successor to the single-channel 16-bit capture block. It drives one shared active-low chip select to N_CH serial ADCs and deserialises their data lines in parallel. It extracts a configurable data field from each frame and presents packed parallel results with a Valid/Ack handshake. It supports continuous and single-shot triggered conversion and sits between the ADC pins and the sample-processing logic.

---
 rtl/adc_serial_capture_multi_if.sv | 29 ++
 rtl/adc_serial_capture_multi.sv | 155 +++++++++++++++
 tb/tb_adc_serial_capture_multi.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_serial_capture_multi_if.sv
// Pin and result bundle between the multi-channel capture engine and its surroundings.
// Latency: none, this is wiring only.
// Backpressure: Valid is held until the consumer returns Ack. There is no stall toward the ADC pins.
// master : environment side. It drives Start, Continuous, DinSerial and Ack.
// slave  : capture engine side. It drives CS, DoutParalelo, Valid, Busy and Overrun.
interface adc_serial_capture_multi_if #(
  parameter int N_CH      = 2,
  parameter int DATA_BITS = 12
);
  logic                      Start;
  logic                      Continuous;
  logic [N_CH-1:0]           DinSerial;
  logic                      Ack;
  logic                      CS;
  logic [N_CH*DATA_BITS-1:0] DoutParalelo;
  logic                      Valid;
  logic                      Busy;
  logic                      Overrun;

  modport master (
    output Start, Continuous, DinSerial, Ack,
    input  CS, DoutParalelo, Valid, Busy, Overrun
  );

  modport slave (
    input  Start, Continuous, DinSerial, Ack,
    output CS, DoutParalelo, Valid, Busy, Overrun
  );
endinterface

// File: rtl/adc_serial_capture_multi.sv
// Purpose: Multi-channel serial ADC capture. One shared active-low CS drives N_CH data lines, which are deserialised MSB first.
// Latency: A result appears in the first GAP cycle after the FRAME_BITS-th CS-low cycle.
// Backpressure: none. A result that is still unacknowledged gets overwritten and raises the sticky Overrun.
// Ports:
//   CLK1MHz, Reset : clock and synchronous active-high reset
//   bus.Start/Continuous : single-shot trigger, sampled in IDLE only, and free-run enable
//   bus.DinSerial : serial data, where bit i belongs to channel i
//   bus.Ack : consumer accepts DoutParalelo
//   bus.CS : ADC chip select, active low
//   bus.DoutParalelo : packed results, with channel i at [i*DATA_BITS +: DATA_BITS]
//   bus.Valid, bus.Busy, bus.Overrun : result flag, state != IDLE, and sticky overwrite flag
// Optional macro ADC_AVG_EN: averages 2**AVG_LOG2 frames per channel before it publishes a result.
module adc_serial_capture_multi #(
  parameter int N_CH       = 2,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int DATA_LSB   = 0,
  parameter int GAP_CYCLES = 1,
  parameter int AVG_LOG2   = 2
) (
  input logic                       CLK1MHz,
  input logic                       Reset,
  adc_serial_capture_multi_if.slave bus
);
  localparam int CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONV, GAP} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          bit_cnt;
  logic [GAP_W-1:0]          gap_cnt;
  logic [FRAME_BITS-2:0]     shift  [N_CH];
  logic [FRAME_BITS-1:0]     word   [N_CH];
  logic [DATA_BITS-1:0]      sample [N_CH];
  logic [N_CH*DATA_BITS-1:0] result;
  logic                      frame_end;
  logic                      load;

  // The frame word includes the bit that is still on the pin. The last bit is therefore
  // never registered, and the word is complete on the frame's final edge.
  always_comb begin
    frame_end = (state == CONV) && (bit_cnt == BIT_LAST);
    for (int i = 0; i < N_CH; i++) begin
      word[i]   = {shift[i], bus.DinSerial[i]};
      sample[i] = DATA_BITS'(word[i] >> DATA_LSB);
    end
  end

`ifdef ADC_AVG_EN
  localparam int ACC_W = DATA_BITS + AVG_LOG2;

  logic [ACC_W-1:0]    acc     [N_CH];
  logic [ACC_W-1:0]    acc_sum [N_CH];
  logic [AVG_LOG2-1:0] frm_cnt;

  // The result is published on the frame where frm_cnt is all ones. On that same edge the counter
  // wraps to zero and the accumulators restart, so no extra clear cycle is needed.
  always_comb begin
    result = '0;
    for (int i = 0; i < N_CH; i++) begin
      acc_sum[i] = acc[i] + ACC_W'(sample[i]);
      result[i*DATA_BITS +: DATA_BITS] = DATA_BITS'(acc_sum[i] >> AVG_LOG2);
    end
    load = frame_end && (&frm_cnt);
  end

  // Partial sums survive a return to IDLE. Only Reset discards them.
  always_ff @(posedge CLK1MHz) begin
    if (Reset) begin
      frm_cnt <= '0;
      for (int i = 0; i < N_CH; i++) acc[i] <= '0;
    end else if (frame_end) begin
      frm_cnt <= frm_cnt + 1'b1;
      for (int i = 0; i < N_CH; i++) acc[i] <= (&frm_cnt) ? '0 : acc_sum[i];
    end
  end
`else
  always_comb begin
    result = '0;
    for (int i = 0; i < N_CH; i++) begin
      result[i*DATA_BITS +: DATA_BITS] = sample[i];
    end
    load = frame_end;
  end
`endif

  always_ff @(posedge CLK1MHz) begin
    if (Reset) begin
      state            <= IDLE;
      bit_cnt          <= '0;
      gap_cnt          <= '0;
      bus.CS           <= 1'b1;
      bus.Busy         <= 1'b0;
      bus.Valid        <= 1'b0;
      bus.Overrun      <= 1'b0;
      bus.DoutParalelo <= '0;
      for (int i = 0; i < N_CH; i++) shift[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start || bus.Continuous) begin
            state    <= CONV;
            bus.CS   <= 1'b0;
            bus.Busy <= 1'b1;
            bit_cnt  <= '0;
          end
        end
        CONV: begin
          for (int i = 0; i < N_CH; i++) shift[i] <= word[i][FRAME_BITS-2:0];
          if (bit_cnt == BIT_LAST) begin
            state   <= GAP;
            bus.CS  <= 1'b1;
            bit_cnt <= '0;
            gap_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            if (bus.Continuous) begin
              state   <= CONV;
              bus.CS  <= 1'b0;
              bit_cnt <= '0;
            end else begin
              state    <= IDLE;
              bus.Busy <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.CS   <= 1'b1;
          bus.Busy <= 1'b0;
        end
      endcase

      // A new result has priority over an Ack on the same edge. Overwriting a result
      // that was never acknowledged is recorded as an overrun.
      if (load) begin
        bus.DoutParalelo <= result;
        bus.Valid        <= 1'b1;
        if (bus.Valid && !bus.Ack) bus.Overrun <= 1'b1;
      end else if (bus.Ack) begin
        bus.Valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_adc_serial_capture_multi.sv
module tb_adc_serial_capture_multi;
  localparam int FB    = 16;
  localparam int GAP   = 1;
  localparam int AVG_N = 4;

  logic CLK1MHz = 1'b0;
  logic Reset;
  always #5 CLK1MHz = ~CLK1MHz;

  adc_serial_capture_multi_if #(.N_CH(2), .DATA_BITS(12)) bus ();
  adc_serial_capture_multi_if #(.N_CH(1), .DATA_BITS(12)) bus2 ();

  // The second engine follows the same ch0 line and the same controls, but it takes its field from bit 2.
  assign bus2.Start      = bus.Start;
  assign bus2.Continuous = bus.Continuous;
  assign bus2.Ack        = bus.Ack;
  assign bus2.DinSerial  = bus.DinSerial[0];

  adc_serial_capture_multi #(.N_CH(2), .FRAME_BITS(16), .DATA_BITS(12), .DATA_LSB(0),
                             .GAP_CYCLES(1), .AVG_LOG2(2)) u_dut (
    .CLK1MHz(CLK1MHz), .Reset(Reset), .bus(bus));

  adc_serial_capture_multi #(.N_CH(1), .FRAME_BITS(16), .DATA_BITS(12), .DATA_LSB(2),
                             .GAP_CYCLES(1), .AVG_LOG2(2)) u_dut_lsb2 (
    .CLK1MHz(CLK1MHz), .Reset(Reset), .bus(bus2));

  int total = 0;
  int bad   = 0;

  // Reference state: what the consumer should currently be able to see.
  logic        exp_valid, exp_ovr;
  logic [23:0] exp_dout;
  logic [11:0] exp_dout2;
  logic        pending;
  logic [15:0] w0, w1;
  logic [15:0] dq0[$], dq1[$];
  int          bitpos, frames_done, frames_started;
  int          sum0, sum1, sum2, avg_cnt;
  logic        in_gap, gap_cont_ok;
  int          gap_len;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock. The task applies what the edge should have done, compares the outputs,
  // and then drives the serial lines for the next edge.
  task automatic tick();
    logic        cont_edge, produce;
    logic [31:0] s0, s1, s2, r0, r1, r2;
    @(posedge CLK1MHz);
    #1;
    cont_edge = bus.Continuous;
    produce   = 1'b0;
    r0 = 0; r1 = 0; r2 = 0;
    if (Reset) begin
      exp_valid = 1'b0; exp_ovr = 1'b0; exp_dout = '0; exp_dout2 = '0;
      pending = 1'b0; bitpos = 0; in_gap = 1'b0;
      sum0 = 0; sum1 = 0; sum2 = 0; avg_cnt = 0;
    end else begin
      if (pending) begin
        s0 = 32'(w0) % 4096;
        s1 = 32'(w1) % 4096;
        s2 = (32'(w0) / 4) % 4096;
        frames_done++;
`ifdef ADC_AVG_EN
        sum0 += s0; sum1 += s1; sum2 += s2; avg_cnt++;
        if (avg_cnt == AVG_N) begin
          produce = 1'b1;
          r0 = sum0 / AVG_N; r1 = sum1 / AVG_N; r2 = sum2 / AVG_N;
          sum0 = 0; sum1 = 0; sum2 = 0; avg_cnt = 0;
        end
`else
        produce = 1'b1;
        r0 = s0; r1 = s1; r2 = s2;
`endif
        pending = 1'b0;
      end
      if (produce) begin
        if (exp_valid && !bus.Ack) exp_ovr = 1'b1;
        exp_valid = 1'b1;
        exp_dout  = {r1[11:0], r0[11:0]};
        exp_dout2 = r2[11:0];
      end else if (bus.Ack) begin
        exp_valid = 1'b0;
      end
    end

    chk("valid",    bus.Valid,         exp_valid);
    chk("dout",     bus.DoutParalelo,  exp_dout);
    chk("overrun",  bus.Overrun,       exp_ovr);
    chk("valid2",   bus2.Valid,        exp_valid);
    chk("dout2",    bus2.DoutParalelo, exp_dout2);
    chk("overrun2", bus2.Overrun,      exp_ovr);

    if (bus.CS == 1'b0) begin
      chk("busy_conv", bus.Busy, 1);
      if (bitpos == FB) begin
        chk("cs_low_len", bitpos + 1, FB);
        bitpos  = 0;
        pending = 1'b0;
      end
      if (bitpos == 0) begin
        if (in_gap) begin
          gap_cont_ok = gap_cont_ok && cont_edge;
          if (gap_cont_ok) chk("gap_len", gap_len, GAP);
        end
        in_gap = 1'b0;
        if (dq0.size() > 0) begin
          w0 = dq0.pop_front();
          w1 = dq1.pop_front();
        end else begin
          w0 = 16'($urandom);
          w1 = 16'($urandom);
        end
        frames_started++;
      end
      bus.DinSerial = {w1[FB-1-bitpos], w0[FB-1-bitpos]};
      bitpos++;
      if (bitpos == FB) pending = 1'b1;
    end else begin
      if (bitpos != 0) begin
        chk("cs_low_len", bitpos, FB);
        bitpos      = 0;
        pending     = 1'b0;
        in_gap      = 1'b1;
        gap_len     = 1;
        gap_cont_ok = 1'b1;
      end else if (in_gap) begin
        gap_len++;
        gap_cont_ok = gap_cont_ok && cont_edge;
      end
      bus.DinSerial = 2'($urandom);
    end
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int target = frames_done + n;
    int guard  = 0;
    while (frames_done < target && guard < 200) begin
      tick();
      guard++;
    end
    if (frames_done < target) chk("frame_timeout", frames_done, target);
  endtask

  task automatic wait_started(input int n);
    int target = frames_started + n;
    int guard  = 0;
    while (frames_started < target && guard < 200) begin
      tick();
      guard++;
    end
    if (frames_started < target) chk("start_timeout", frames_started, target);
  endtask

  task automatic wait_idle();
    int guard = 0;
    tick();
    while (bus.Busy && guard < 200) begin
      tick();
      guard++;
    end
    chk("idle_busy", bus.Busy, 0);
    chk("idle_cs",   bus.CS,   1);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    int guard;
    exp_valid = 1'b0; exp_ovr = 1'b0; exp_dout = '0; exp_dout2 = '0;
    pending = 1'b0; bitpos = 0; frames_done = 0; frames_started = 0;
    sum0 = 0; sum1 = 0; sum2 = 0; avg_cnt = 0;
    in_gap = 1'b0; gap_cont_ok = 1'b0; gap_len = 0;
    w0 = '0; w1 = '0;
    Reset = 1'b1;
    bus.Start = 1'b0; bus.Continuous = 1'b0; bus.Ack = 1'b0; bus.DinSerial = '0;

    tick();
    tick();
    chk("rst_cs",    bus.CS,           1);
    chk("rst_busy",  bus.Busy,         0);
    chk("rst_valid", bus.Valid,        0);
    chk("rst_dout",  bus.DoutParalelo, 0);
    chk("rst_ovr",   bus.Overrun,      0);
    Reset = 1'b0;
    tick();

    // Single shot. A second Start in mid-frame must not disturb the frame.
    dq0.push_back(16'h0ABC); dq1.push_back(16'h0123);
    pulse_start();
    repeat (4) tick();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    wait_frames(1);
    chk("t1_cs_gap", bus.CS, 1);
`ifndef ADC_AVG_EN
    chk("t1_valid", bus.Valid,         1);
    chk("t1_dout",  bus.DoutParalelo,  24'h123ABC);
    chk("t1_dout2", bus2.DoutParalelo, 12'h2AF);
`endif
    wait_idle();

    // Continuous mode with Ack held high.
    bus.Ack = 1'b1;
    dq0.push_back(16'h0001); dq1.push_back(16'h0000);
    dq0.push_back(16'h0002); dq1.push_back(16'h0000);
    dq0.push_back(16'h0003); dq1.push_back(16'h0000);
    bus.Continuous = 1'b1;
    wait_started(3);
    bus.Continuous = 1'b0;
    wait_idle();
    chk("t2_ovr", bus.Overrun, 0);
`ifndef ADC_AVG_EN
    chk("t2_dout", bus.DoutParalelo, 24'h000003);
`endif

    // Continuous mode with Ack held low: the second result overwrites the first.
    bus.Ack = 1'b0;
    dq0.push_back(16'h0055); dq1.push_back(16'h0AA0);
    dq0.push_back(16'h0123); dq1.push_back(16'h0456);
    bus.Continuous = 1'b1;
    wait_started(2);
    bus.Continuous = 1'b0;
    wait_idle();
`ifndef ADC_AVG_EN
    chk("t3_valid", bus.Valid,        1);
    chk("t3_ovr",   bus.Overrun,      1);
    chk("t3_dout",  bus.DoutParalelo, 24'h456123);
`endif
    bus.Ack = 1'b1;
    tick();
    bus.Ack = 1'b0;
    chk("t3_ack_clear", bus.Valid, 0);

    // Reset in the middle of a frame, then a clean capture.
    dq0.push_back(16'h1234); dq1.push_back(16'h0567);
    pulse_start();
    guard = 0;
    while (bitpos < 8 && guard < 50) begin
      tick();
      guard++;
    end
    chk("t4_reach_bit8", bitpos, 8);
    do_reset();
    chk("t4_cs",    bus.CS,           1);
    chk("t4_valid", bus.Valid,        0);
    chk("t4_dout",  bus.DoutParalelo, 0);
    chk("t4_busy",  bus.Busy,         0);
    chk("t4_ovr",   bus.Overrun,      0);
    dq0.push_back(16'h0FFF); dq1.push_back(16'h0000);
    pulse_start();
    wait_frames(1);
`ifndef ADC_AVG_EN
    chk("t4_ch0", bus.DoutParalelo[11:0], 12'hFFF);
`endif
    wait_idle();

    // The field at bit 2 on the second engine.
    dq0.push_back(16'b0011_1111_1111_1100); dq1.push_back(16'h0000);
    pulse_start();
    wait_frames(1);
`ifndef ADC_AVG_EN
    chk("t5_lsb2", bus2.DoutParalelo,     12'hFFF);
    chk("t5_ch0",  bus.DoutParalelo[11:0], 12'hFFC);
`endif
    wait_idle();

`ifdef ADC_AVG_EN
    // Averaging: four frames produce exactly one result.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: dq0.push_back(16'd10);
        1: dq0.push_back(16'd20);
        2: dq0.push_back(16'd30);
        default: dq0.push_back(16'd41);
      endcase
      dq1.push_back(16'h0000);
      pulse_start();
      wait_frames(1);
      if (k < 3) begin
        chk("avg_novalid", bus.Valid, 0);
      end else begin
        chk("avg_valid", bus.Valid,               1);
        chk("avg_ch0",   bus.DoutParalelo[11:0], 25);
      end
      wait_idle();
    end
`endif

    // Random traffic: triggers, continuous toggling, sparse Ack and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      bus.Start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) bus.Continuous = ~bus.Continuous;
      bus.Ack = ($urandom_range(0, 2) == 0);
      Reset   = ($urandom_range(0, 399) == 0);
      tick();
    end
    Reset = 1'b0;
    bus.Start = 1'b0;
    bus.Continuous = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
